// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Used by the receive core and any block that needs the frame geometry.
// Holds no logic, so it adds no latency and has no flow control.
package uart_pkg;

  localparam int OSR     = 16;
  localparam int DATALEN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } states_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input; resets to 1 (idle line).
// Latency: 2 clk from input to q_o.
// No backpressure: it samples every clock.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the raw input through two flops; the first may go metastable.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampling 8N1 UART receiver with RBR/LSR-style valid/ack, FE and OE flags.
// Latency: rx_valid rises 1 clk after the stop-bit decision tick.
// Backpressure: none on the line; a frame completing while rx_valid=1 is dropped and sets overrun_err.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, decision taken one tick later.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OSR     = uart_pkg::OSR,
  parameter int DATALEN = uart_pkg::DATALEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               baud_tick,
  input  logic               rxd,
  output logic [DATALEN-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ack,
  output logic               frame_err,
  output logic               overrun_err,
  output logic               busy
);

  localparam int TW = $clog2(OSR);
  localparam int BW = (DATALEN > 1) ? $clog2(DATALEN) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the nominal point, so each decision lands
  // one tick late; restarting the counter at 1 keeps later sample points fixed.
  localparam logic [TW-1:0] START_DEC = TW'(OSR / 2);
  localparam logic [TW-1:0] BIT_DEC   = '0;
  localparam logic [TW-1:0] DEC_NEXT  = TW'(1);
`else
  localparam logic [TW-1:0] START_DEC = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] BIT_DEC   = TICK_LAST;
  localparam logic [TW-1:0] DEC_NEXT  = '0;
`endif

  states_e            state_q, state_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d, tick_inc;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATALEN-1:0] shift_q, shift_d;
  logic               break_hold_q, break_hold_d;
  logic [DATALEN-1:0] rx_data_q;
  logic               rx_valid_q, frame_err_q, overrun_q;
  logic               rxd_s, sample, done;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] samp_q, samp_d;
  assign samp_d = {samp_q[1:0], rxd_s};
  assign sample = (samp_d[2] & samp_d[1]) | (samp_d[2] & samp_d[0]) | (samp_d[1] & samp_d[0]);

  // Keep the most recent line samples, one per baud tick.
  always_ff @(posedge clk) begin
    if (!rst_n)         samp_q <= '1;
    else if (baud_tick) samp_q <= samp_d;
  end
`else
  assign sample = rxd_s;
`endif

  assign tick_inc = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);

  // Next-state logic: everything advances only on baud ticks.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    break_hold_d = break_hold_q;
    done         = 1'b0;
    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          tick_cnt_d = '0;
          if (break_hold_q) begin
            // After a low stop bit, require the line to return high first.
            if (rxd_s) break_hold_d = 1'b0;
          end else if (!rxd_s) begin
            state_d = START;
          end
        end
        START: begin
          tick_cnt_d = tick_inc;
          if (tick_cnt_q == START_DEC) begin
            if (sample) begin
              state_d    = IDLE;
              tick_cnt_d = '0;
            end else begin
              state_d    = DATA;
              tick_cnt_d = DEC_NEXT;
              bit_cnt_d  = '0;
            end
          end
        end
        DATA: begin
          tick_cnt_d = tick_inc;
          if (tick_cnt_q == BIT_DEC) begin
            shift_d    = {sample, shift_q[DATALEN-1:1]};
            tick_cnt_d = DEC_NEXT;
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(DATALEN - 1)) state_d = STOP;
          end
        end
        STOP: begin
          tick_cnt_d = tick_inc;
          if (tick_cnt_q == BIT_DEC) begin
            done         = 1'b1;
            state_d      = IDLE;
            tick_cnt_d   = '0;
            break_hold_d = ~sample;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, counters and shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      break_hold_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      break_hold_q <= break_hold_d;
    end
  end

  // Receive buffer and status flags; a completing frame takes priority over ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (done) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_q   <= shift_q;
        frame_err_q <= ~sample;
        rx_valid_q  <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: drives 8N1 frames tick by tick and compares against a flag-level model.
// Frame timing is expressed in baud ticks counted from the start-bit edge.
// Build with UART_RX_MAJORITY_EN to exercise the voting receiver.
module tb_uart_rx_core;

  localparam int OSR = 16;
  localparam int DL  = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Tick (1-based, from the start edge) on which the stop bit is decided.
  localparam int DONE_T  = OSR / 2 + 1 + 9 * OSR + MAJ;
  localparam int FRAME_T = 10 * OSR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          baud_tick = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ack = 1'b0;
  logic [DL-1:0] rx_data;
  logic          rx_valid, frame_err, overrun_err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_div = 4;
  int div_cnt = 0;

  uart_rx_core #(.OSR(OSR), .DATALEN(DL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  // Baud tick generator: one pulse every tick_div clocks (continuous when tick_div <= 1).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_div <= 1) baud_tick = 1'b1;
      else begin
        div_cnt   = (div_cnt + 1) % tick_div;
        baud_tick = (div_cnt == 0);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Returns 1 time unit after the next tick edge; optionally acks in that tick cycle.
  task automatic wait_tick(input bit ack);
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (baud_tick === 1'b1) begin
        if (ack) rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
        return;
      end
      guard++;
      if (guard > 64) begin
        n_cmp++; n_bad++;
        $display("FAIL tick_timeout: got no baud_tick in %0d clk, want one", guard);
        return;
      end
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  // Drive a frame: start, 8 data LSB first, stop. Level for tick t is set just after tick t-1.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_t,
                            input int last_t, input int ack_t, input bit chk);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int t = 1; t <= last_t; t++) begin
      rxd = (t == glitch_t) ? 1'b0 : bits[(t - 1) / OSR];
      wait_tick(t == ack_t);
      if (chk && t == DONE_T - 1) begin
        n_cmp++;
        if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL valid_early: got %b want 0", rx_valid); end
      end
      if (chk && t == DONE_T) begin
        n_cmp++;
        if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL valid_rise: got %b want 1", rx_valid); end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, overrun_err, busy} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b want 00/0000", rx_data, rx_valid, frame_err, overrun_err, busy);
    end
    rst_n = 1'b1;
    repeat (4) wait_tick(1'b0);
  endtask

  task automatic test_basic();
    tick_div = 4;
    send_frame(8'hA5, 1'b1, 0, FRAME_T, 0, 1'b1);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err} !== {8'hA5, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL basic_a5: got %h v%b fe%b want a5 v1 fe0", rx_data, rx_valid, frame_err);
    end
    ack_pulse();
    n_cmp++;
    if ({rx_data, rx_valid} !== {8'hA5, 1'b0}) begin
      n_bad++; $display("FAIL basic_ack: got %h v%b want a5 v0", rx_data, rx_valid);
    end
  endtask

  task automatic test_glitch();
    wait_tick(1'b0);
    rxd = 1'b0;
    repeat (3) wait_tick(1'b0);
    rxd = 1'b1;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy: got %b want 1", busy); end
    repeat (OSR) wait_tick(1'b0);
    n_cmp++;
    if ({busy, rx_valid} !== 2'b00) begin
      n_bad++; $display("FAIL glitch_abort: got busy%b v%b want busy0 v0", busy, rx_valid);
    end
  endtask

  task automatic test_break();
    bit seen_busy, seen_valid;
    send_frame(8'h3C, 1'b0, 0, FRAME_T, 0, 1'b1);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err} !== {8'h3C, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL break_frame: got %h v%b fe%b want 3c v1 fe1", rx_data, rx_valid, frame_err);
    end
    ack_pulse();
    seen_busy = 1'b0; seen_valid = 1'b0;
    repeat (2 * OSR) begin
      wait_tick(1'b0);
      if (busy) seen_busy = 1'b1;
      if (rx_valid) seen_valid = 1'b1;
    end
    n_cmp++;
    if ({seen_busy, seen_valid} !== 2'b00) begin
      n_bad++; $display("FAIL break_hold: got busy%b v%b want busy0 v0", seen_busy, seen_valid);
    end
    rxd = 1'b1;
    repeat (OSR) wait_tick(1'b0);
    send_frame(8'h96, 1'b1, 0, FRAME_T, 0, 1'b1);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err} !== {8'h96, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL break_recover: got %h v%b fe%b want 96 v1 fe0", rx_data, rx_valid, frame_err);
    end
    ack_pulse();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 0, FRAME_T, 0, 1'b1);
    send_frame(8'h22, 1'b1, 0, FRAME_T, 0, 1'b0);
    n_cmp++;
    if ({rx_data, rx_valid, overrun_err, frame_err} !== {8'h11, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL overrun_set: got %h v%b oe%b fe%b want 11 v1 oe1 fe0", rx_data, rx_valid, overrun_err, frame_err);
    end
    ack_pulse();
    n_cmp++;
    if ({rx_data, rx_valid, overrun_err} !== {8'h11, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL overrun_clear: got %h v%b oe%b want 11 v0 oe0", rx_data, rx_valid, overrun_err);
    end
    send_frame(8'h11, 1'b1, 0, FRAME_T, 0, 1'b1);
    send_frame(8'h22, 1'b1, 0, FRAME_T, DONE_T, 1'b0);
    n_cmp++;
    if ({rx_data, rx_valid, overrun_err} !== {8'h22, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL ack_on_done: got %h v%b oe%b want 22 v1 oe0", rx_data, rx_valid, overrun_err);
    end
    ack_pulse();
  endtask

  task automatic test_reset_mid_frame();
    bit seen_valid;
    send_frame(8'hC3, 1'b1, 0, FRAME_T, 0, 1'b1);
    // Stop partway through data bit 4 (frame slot 5).
    send_frame(8'h77, 1'b1, 0, 5 * OSR + OSR / 2, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, overrun_err, busy} !== 12'h000) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h/%b%b%b%b want 00/0000", rx_data, rx_valid, frame_err, overrun_err, busy);
    end
    rxd = 1'b1;
    seen_valid = 1'b0;
    repeat (2 * OSR) begin
      wait_tick(1'b0);
      if (rx_valid) seen_valid = 1'b1;
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_nodeliver: got v%b want v0", seen_valid); end
    send_frame(8'h5A, 1'b1, 0, FRAME_T, 0, 1'b1);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, overrun_err} !== {8'h5A, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL midreset_5a: got %h v%b fe%b oe%b want 5a v1 fe0 oe0", rx_data, rx_valid, frame_err, overrun_err);
    end
    ack_pulse();
  endtask

  task automatic test_majority();
    logic [7:0] expv;
    expv = (MAJ != 0) ? 8'hFF : 8'hFB;
    tick_div = 4;
    // Nominal sample point of data bit 2 lies mid-way through frame slot 3.
    send_frame(8'hFF, 1'b1, 3 * OSR + OSR / 2 + 1, FRAME_T, 0, 1'b1);
    n_cmp++;
    if ({rx_data, rx_valid} !== {expv, 1'b1}) begin
      n_bad++; $display("FAIL bit2_glitch: got %h v%b want %h v1", rx_data, rx_valid, expv);
    end
    ack_pulse();
  endtask

  task automatic test_random();
    logic [7:0] m_data, b;
    logic       m_valid, m_fe, m_ovr, stop;
    int         divs[5];
    divs = '{1, 3, 4, 5, 6};
    m_data = rx_data; m_valid = 1'b0; m_fe = frame_err; m_ovr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick_div = divs[$urandom_range(0, 4)];
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      rxd  = 1'b1;
      repeat ($urandom_range(2, 12)) wait_tick(1'b0);
      send_frame(b, stop, 0, FRAME_T, 0, (!m_valid) && (tick_div >= 3));
      if (!m_valid) begin
        m_data = b; m_fe = ~stop; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      n_cmp++;
      if ({rx_data, rx_valid, frame_err, overrun_err} !== {m_data, m_valid, m_fe, m_ovr}) begin
        n_bad++;
        $display("FAIL random_%0d: got %h v%b fe%b oe%b want %h v%b fe%b oe%b", i,
                 rx_data, rx_valid, frame_err, overrun_err, m_data, m_valid, m_fe, m_ovr);
      end
      if ($urandom_range(0, 2) != 0) begin
        ack_pulse();
        if (m_valid) begin m_valid = 1'b0; m_ovr = 1'b0; end
        n_cmp++;
        if ({rx_valid, overrun_err} !== {m_valid, m_ovr}) begin
          n_bad++; $display("FAIL random_ack_%0d: got v%b oe%b want v%b oe%b", i, rx_valid, overrun_err, m_valid, m_ovr);
        end
      end
    end
    rxd = 1'b1;
    ack_pulse();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid_frame();
    test_majority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
